// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: in-order FIFO of {PC, instruction}
// pairs with valid/ready handshakes on both sides and a flush for redirects.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       InstructionIn,
  input  logic [31:0]       PCIn,
  input  logic              InValid,
  output logic              InReady,
  input  logic              Flush,
  output logic [31:0]       InstructionOut,
  output logic [31:0]       PCOut,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [CNT_W-1:0]  Count
);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;
  logic [63:0]      head;

  // InReady depends on occupancy only, so a full queue refuses a pair even while popping.
  assign InReady  = (cnt != CNT_W'(DEPTH));
  assign OutValid = (cnt != '0);
  assign push     = InValid & InReady & ~Flush;
  assign pop      = OutValid & OutReady & ~Flush;
  assign Count    = cnt;

  always_comb begin
    head = '0;
    if (OutValid) head = mem[rp];
  end

  assign PCOut          = head[63:32];
  assign InstructionOut = head[31:0];

  always_ff @(posedge Clk) begin
    if (push) mem[wp] <= {PCIn, InstructionIn};
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (Flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PTR_W'(1);
      if (pop)  rp <= rp + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
